// File: rtl/axi_mm_outstanding_limiter_if.sv
// AXI memory-mapped bus bundle (AW/W/B/AR/R plus clock/reset) shared by
// the limiter's upstream and downstream sides.
interface ofs_axi_mm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic                clk;
  logic                rst_n;

  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;

  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic                rvalid;
  logic                rready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;

  modport manager (
    output clk, rst_n,
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready
  );

  modport subordinate (
    input  clk, rst_n,
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );
endinterface

// File: rtl/axi_mm_outstanding_limiter.sv
// Caps outstanding AXI write/read bursts and supports quiesce/drain.
// Optional AXI_MM_LIMITER_STATS_EN adds peak-occupancy outputs wr_peak/rd_peak.
module axi_mm_outstanding_limiter #(
  parameter int MAX_WR_OUTSTANDING = 16,
  parameter int MAX_RD_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ofs_axi_mm_if.subordinate       s_if,
  ofs_axi_mm_if.manager           m_if,
  input  logic                    quiesce_req,
  output logic                    quiesced,
  output logic [7:0]              wr_outstanding,
  output logic [7:0]              rd_outstanding,
`ifdef AXI_MM_LIMITER_STATS_EN
  output logic [7:0]              wr_peak,
  output logic [7:0]              rd_peak,
`endif
  output logic                    err_underflow
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

  localparam logic [7:0] LP_WR_MAX = 8'(MAX_WR_OUTSTANDING);
  localparam logic [7:0] LP_RD_MAX = 8'(MAX_RD_OUTSTANDING);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_wr_cnt, r_rd_cnt, w_wr_cnt_nxt, w_rd_cnt_nxt;
  logic       r_err, w_wr_uf, w_rd_uf;
  logic       w_aw_allow, w_ar_allow;
  logic       w_aw_hs, w_ar_hs, w_b_hs, w_r_last_hs;

  assign m_if.clk   = clk;
  assign m_if.rst_n = ~rst;

  assign w_aw_allow = (r_state == ST_RUN) && (r_wr_cnt < LP_WR_MAX);
  assign w_ar_allow = (r_state == ST_RUN) && (r_rd_cnt < LP_RD_MAX);

  assign m_if.awvalid = s_if.awvalid & w_aw_allow;
  assign s_if.awready = m_if.awready & w_aw_allow;
  assign m_if.awid    = s_if.awid;
  assign m_if.awaddr  = s_if.awaddr;
  assign m_if.awlen   = s_if.awlen;
  assign m_if.awsize  = s_if.awsize;
  assign m_if.awburst = s_if.awburst;

  assign m_if.wvalid  = s_if.wvalid;
  assign s_if.wready  = m_if.wready;
  assign m_if.wdata   = s_if.wdata;
  assign m_if.wstrb   = s_if.wstrb;
  assign m_if.wlast   = s_if.wlast;

  assign s_if.bvalid  = m_if.bvalid;
  assign m_if.bready  = s_if.bready;
  assign s_if.bid     = m_if.bid;
  assign s_if.bresp   = m_if.bresp;

  assign m_if.arvalid = s_if.arvalid & w_ar_allow;
  assign s_if.arready = m_if.arready & w_ar_allow;
  assign m_if.arid    = s_if.arid;
  assign m_if.araddr  = s_if.araddr;
  assign m_if.arlen   = s_if.arlen;
  assign m_if.arsize  = s_if.arsize;
  assign m_if.arburst = s_if.arburst;

  assign s_if.rvalid  = m_if.rvalid;
  assign m_if.rready  = s_if.rready;
  assign s_if.rid     = m_if.rid;
  assign s_if.rdata   = m_if.rdata;
  assign s_if.rresp   = m_if.rresp;
  assign s_if.rlast   = m_if.rlast;

  assign w_aw_hs     = s_if.awvalid & m_if.awready & w_aw_allow;
  assign w_ar_hs     = s_if.arvalid & m_if.arready & w_ar_allow;
  assign w_b_hs      = m_if.bvalid & s_if.bready;
  assign w_r_last_hs = m_if.rvalid & s_if.rready & m_if.rlast;

  always_comb begin
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    w_wr_uf      = 1'b0;
    w_rd_uf      = 1'b0;
    if (w_aw_hs && !w_b_hs) begin
      w_wr_cnt_nxt = r_wr_cnt + 8'd1;
    end else if (!w_aw_hs && w_b_hs) begin
      if (r_wr_cnt == 8'd0) w_wr_uf = 1'b1;
      else                  w_wr_cnt_nxt = r_wr_cnt - 8'd1;
    end
    if (w_ar_hs && !w_r_last_hs) begin
      w_rd_cnt_nxt = r_rd_cnt + 8'd1;
    end else if (!w_ar_hs && w_r_last_hs) begin
      if (r_rd_cnt == 8'd0) w_rd_uf = 1'b1;
      else                  w_rd_cnt_nxt = r_rd_cnt - 8'd1;
    end
  end

  // A handshake accepted in the cycle quiesce rises still counts, so going
  // straight to IDLE additionally requires that nothing is being accepted now.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (quiesce_req) begin
          if (r_wr_cnt == 8'd0 && r_rd_cnt == 8'd0 && !w_aw_hs && !w_ar_hs)
            w_state_nxt = ST_IDLE;
          else
            w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!quiesce_req)
          w_state_nxt = ST_RUN;
        else if (r_wr_cnt == 8'd0 && r_rd_cnt == 8'd0)
          w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!quiesce_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_wr_cnt <= 8'd0;
      r_rd_cnt <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_err    <= r_err | w_wr_uf | w_rd_uf;
    end
  end

  assign quiesced       = (r_state == ST_IDLE);
  assign wr_outstanding = r_wr_cnt;
  assign rd_outstanding = r_rd_cnt;
  assign err_underflow  = r_err;

`ifdef AXI_MM_LIMITER_STATS_EN
  logic [7:0] r_wr_peak, r_rd_peak;

  // Peaks follow the registered counts, so they lag a count change by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_peak <= 8'd0;
      r_rd_peak <= 8'd0;
    end else begin
      if (r_wr_cnt > r_wr_peak) r_wr_peak <= r_wr_cnt;
      if (r_rd_cnt > r_rd_peak) r_rd_peak <= r_rd_cnt;
    end
  end

  assign wr_peak = r_wr_peak;
  assign rd_peak = r_rd_peak;
`endif

endmodule

// File: tb/tb_axi_mm_outstanding_limiter.sv
// Directed testbench for axi_mm_outstanding_limiter with both limits set to 4;
// expected values are hand-computed per scenario.
module tb_axi_mm_outstanding_limiter;

  logic       clk;
  logic       rst;
  logic       quiesceReq;
  logic       quiesced;
  logic [7:0] wrOut;
  logic [7:0] rdOut;
  logic       errUf;
`ifdef AXI_MM_LIMITER_STATS_EN
  logic [7:0] wrPeak;
  logic [7:0] rdPeak;
`endif

  int errors = 0;
  int checks = 0;

  ofs_axi_mm_if sBus ();
  ofs_axi_mm_if mBus ();

  assign sBus.clk   = clk;
  assign sBus.rst_n = ~rst;

  axi_mm_outstanding_limiter #(
    .MAX_WR_OUTSTANDING(4),
    .MAX_RD_OUTSTANDING(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_if           (sBus),
    .m_if           (mBus),
    .quiesce_req    (quiesceReq),
    .quiesced       (quiesced),
    .wr_outstanding (wrOut),
    .rd_outstanding (rdOut),
`ifdef AXI_MM_LIMITER_STATS_EN
    .wr_peak        (wrPeak),
    .rd_peak        (rdPeak),
`endif
    .err_underflow  (errUf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    quiesceReq    = 1'b0;
    sBus.awvalid  = 1'b0; sBus.awid = '0; sBus.awaddr = '0; sBus.awlen = '0;
    sBus.awsize   = 3'd3; sBus.awburst = 2'b01;
    sBus.wvalid   = 1'b0; sBus.wdata = '0; sBus.wstrb = '1; sBus.wlast = 1'b0;
    sBus.bready   = 1'b1;
    sBus.arvalid  = 1'b0; sBus.arid = '0; sBus.araddr = '0; sBus.arlen = '0;
    sBus.arsize   = 3'd3; sBus.arburst = 2'b01;
    sBus.rready   = 1'b1;
    mBus.awready  = 1'b1; mBus.wready = 1'b1; mBus.arready = 1'b1;
    mBus.bvalid   = 1'b0; mBus.bid = '0; mBus.bresp = '0;
    mBus.rvalid   = 1'b0; mBus.rid = '0; mBus.rdata = '0; mBus.rresp = '0;
    mBus.rlast    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (wrOut !== 8'd0) begin errors++; $display("[TB] FAIL reset_wr: got %0d expected 0", wrOut); end
    checks++; if (rdOut !== 8'd0) begin errors++; $display("[TB] FAIL reset_rd: got %0d expected 0", rdOut); end
    checks++; if (quiesced !== 1'b0) begin errors++; $display("[TB] FAIL reset_quiesced: got %b expected 0", quiesced); end
    checks++; if (errUf !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", errUf); end
    checks++; if (mBus.rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_rst_n_low: got %b expected 0", mBus.rst_n); end
    checks++; if (sBus.awready !== 1'b1) begin errors++; $display("[TB] FAIL reset_awready: got %b expected 1", sBus.awready); end
    checks++; if (sBus.arready !== 1'b1) begin errors++; $display("[TB] FAIL reset_arready: got %b expected 1", sBus.arready); end
    rst = 1'b0;
    tick();
    checks++; if (mBus.rst_n !== 1'b1) begin errors++; $display("[TB] FAIL rst_n_high: got %b expected 1", mBus.rst_n); end
  endtask

  task automatic test_passthrough();
    sBus.awaddr = 32'hDEAD_BEEF;
    sBus.wdata  = 64'h0123_4567_89AB_CDEF;
    mBus.rdata  = 64'hCAFE_F00D_1234_5678;
    mBus.bresp  = 2'b10;
    mBus.bvalid = 1'b1;
    sBus.bready = 1'b0;
    #1;
    checks++; if (mBus.awaddr !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL pass_awaddr: got %h expected deadbeef", mBus.awaddr); end
    checks++; if (mBus.wdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("[TB] FAIL pass_wdata: got %h expected 0123456789abcdef", mBus.wdata); end
    checks++; if (sBus.rdata !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("[TB] FAIL pass_rdata: got %h expected cafef00d12345678", sBus.rdata); end
    checks++; if (sBus.bresp !== 2'b10) begin errors++; $display("[TB] FAIL pass_bresp: got %b expected 10", sBus.bresp); end
    checks++; if (sBus.bvalid !== 1'b1) begin errors++; $display("[TB] FAIL pass_bvalid: got %b expected 1", sBus.bvalid); end
    tick();
    checks++; if (wrOut !== 8'd0) begin errors++; $display("[TB] FAIL pass_no_b_hs: got %0d expected 0", wrOut); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    logic [7:0] expCnt;
    sBus.awvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (sBus.awready !== (i < 4)) begin errors++; $display("[TB] FAIL sat_awready[%0d]: got %b expected %b", i, sBus.awready, (i < 4)); end
      checks++; if (mBus.awvalid !== (i < 4)) begin errors++; $display("[TB] FAIL sat_m_awvalid[%0d]: got %b expected %b", i, mBus.awvalid, (i < 4)); end
      tick();
      expCnt = (i < 4) ? 8'(i + 1) : 8'd4;
      checks++; if (wrOut !== expCnt) begin errors++; $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", i, wrOut, expCnt); end
    end
    mBus.bvalid = 1'b1;
    tick();
    mBus.bvalid = 1'b0;
    checks++; if (wrOut !== 8'd3) begin errors++; $display("[TB] FAIL sat_after_b: got %0d expected 3", wrOut); end
    #1;
    checks++; if (sBus.awready !== 1'b1) begin errors++; $display("[TB] FAIL sat_fifth_ready: got %b expected 1", sBus.awready); end
    tick();
    sBus.awvalid = 1'b0;
    checks++; if (wrOut !== 8'd4) begin errors++; $display("[TB] FAIL sat_fifth_cnt: got %0d expected 4", wrOut); end
    mBus.bvalid = 1'b1;
    repeat (4) tick();
    mBus.bvalid = 1'b0;
    checks++; if (wrOut !== 8'd0) begin errors++; $display("[TB] FAIL sat_drain_cnt: got %0d expected 0", wrOut); end
    checks++; if (errUf !== 1'b0) begin errors++; $display("[TB] FAIL sat_no_err: got %b expected 0", errUf); end
  endtask

  task automatic test_read();
    sBus.arvalid = 1'b1;
    sBus.arlen   = 8'd3;
    tick();
    sBus.arvalid = 1'b0;
    checks++; if (rdOut !== 8'd1) begin errors++; $display("[TB] FAIL rd_issue: got %0d expected 1", rdOut); end
    for (int b = 0; b < 4; b++) begin
      mBus.rvalid = 1'b1;
      mBus.rlast  = (b == 3);
      tick();
      checks++; if (rdOut !== ((b == 3) ? 8'd0 : 8'd1)) begin errors++; $display("[TB] FAIL rd_beat[%0d]: got %0d expected %0d", b, rdOut, (b == 3) ? 0 : 1); end
    end
    mBus.rvalid = 1'b0;
    mBus.rlast  = 1'b0;
  endtask

  task automatic test_simultaneous();
    sBus.awvalid = 1'b1;
    repeat (2) tick();
    checks++; if (wrOut !== 8'd2) begin errors++; $display("[TB] FAIL simul_pre: got %0d expected 2", wrOut); end
    mBus.bvalid = 1'b1;
    tick();
    sBus.awvalid = 1'b0;
    checks++; if (wrOut !== 8'd2) begin errors++; $display("[TB] FAIL simul_hold: got %0d expected 2", wrOut); end
    repeat (2) tick();
    mBus.bvalid = 1'b0;
    checks++; if (wrOut !== 8'd0) begin errors++; $display("[TB] FAIL simul_post: got %0d expected 0", wrOut); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 3; i++) begin
      sBus.awvalid = 1'b1;
      sBus.arvalid = (i < 2);
      tick();
    end
    sBus.awvalid = 1'b0;
    sBus.arvalid = 1'b0;
    checks++; if (wrOut !== 8'd3 || rdOut !== 8'd2) begin errors++; $display("[TB] FAIL drain_setup: got wr=%0d rd=%0d expected wr=3 rd=2", wrOut, rdOut); end
    quiesceReq = 1'b1;
    tick();
    sBus.awvalid = 1'b1;
    sBus.arvalid = 1'b1;
    #1;
    checks++; if (sBus.awready !== 1'b0 || sBus.arready !== 1'b0) begin errors++; $display("[TB] FAIL drain_block: got aw=%b ar=%b expected 0 0", sBus.awready, sBus.arready); end
    checks++; if (mBus.awvalid !== 1'b0) begin errors++; $display("[TB] FAIL drain_m_awvalid: got %b expected 0", mBus.awvalid); end
    tick();
    checks++; if (wrOut !== 8'd3 || rdOut !== 8'd2) begin errors++; $display("[TB] FAIL drain_hold: got wr=%0d rd=%0d expected wr=3 rd=2", wrOut, rdOut); end
    checks++; if (quiesced !== 1'b0) begin errors++; $display("[TB] FAIL drain_not_quiesced: got %b expected 0", quiesced); end
    mBus.bvalid = 1'b1;
    mBus.rvalid = 1'b1;
    mBus.rlast  = 1'b1;
    repeat (2) tick();
    mBus.rvalid = 1'b0;
    mBus.rlast  = 1'b0;
    tick();
    mBus.bvalid = 1'b0;
    checks++; if (wrOut !== 8'd0 || rdOut !== 8'd0) begin errors++; $display("[TB] FAIL drain_empty: got wr=%0d rd=%0d expected 0 0", wrOut, rdOut); end
    tick();
    checks++; if (quiesced !== 1'b1) begin errors++; $display("[TB] FAIL drain_quiesced: got %b expected 1", quiesced); end
    #1;
    checks++; if (sBus.awready !== 1'b0) begin errors++; $display("[TB] FAIL idle_block: got %b expected 0", sBus.awready); end
    quiesceReq = 1'b0;
    tick();
    checks++; if (quiesced !== 1'b0) begin errors++; $display("[TB] FAIL resume_quiesced: got %b expected 0", quiesced); end
    #1;
    checks++; if (sBus.awready !== 1'b1) begin errors++; $display("[TB] FAIL resume_awready: got %b expected 1", sBus.awready); end
    tick();
    sBus.awvalid = 1'b0;
    sBus.arvalid = 1'b0;
    checks++; if (wrOut !== 8'd1 || rdOut !== 8'd1) begin errors++; $display("[TB] FAIL resume_accept: got wr=%0d rd=%0d expected 1 1", wrOut, rdOut); end
    mBus.bvalid = 1'b1;
    mBus.rvalid = 1'b1;
    mBus.rlast  = 1'b1;
    tick();
    mBus.bvalid = 1'b0;
    mBus.rvalid = 1'b0;
    mBus.rlast  = 1'b0;
  endtask

  task automatic test_underflow();
    checks++; if (wrOut !== 8'd0 || errUf !== 1'b0) begin errors++; $display("[TB] FAIL uf_pre: got wr=%0d err=%b expected 0 0", wrOut, errUf); end
    mBus.bvalid = 1'b1;
    tick();
    mBus.bvalid = 1'b0;
    checks++; if (errUf !== 1'b1) begin errors++; $display("[TB] FAIL uf_set: got %b expected 1", errUf); end
    checks++; if (wrOut !== 8'd0) begin errors++; $display("[TB] FAIL uf_cnt: got %0d expected 0", wrOut); end
    mBus.rvalid = 1'b1;
    mBus.rlast  = 1'b1;
    tick();
    mBus.rvalid = 1'b0;
    mBus.rlast  = 1'b0;
    tick();
    checks++; if (errUf !== 1'b1) begin errors++; $display("[TB] FAIL uf_sticky: got %b expected 1", errUf); end
    checks++; if (rdOut !== 8'd0) begin errors++; $display("[TB] FAIL uf_rd_cnt: got %0d expected 0", rdOut); end
  endtask

  task automatic test_reset_mid();
    sBus.awvalid = 1'b1;
    repeat (3) tick();
    sBus.awvalid = 1'b0;
    checks++; if (wrOut !== 8'd3) begin errors++; $display("[TB] FAIL mid_pre: got %0d expected 3", wrOut); end
`ifdef AXI_MM_LIMITER_STATS_EN
    checks++; if (wrPeak !== 8'd4) begin errors++; $display("[TB] FAIL mid_peak_pre: got %0d expected 4", wrPeak); end
`endif
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wrOut !== 8'd0) begin errors++; $display("[TB] FAIL mid_async_wr: got %0d expected 0", wrOut); end
    checks++; if (errUf !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_err: got %b expected 0", errUf); end
    checks++; if (quiesced !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_quiesced: got %b expected 0", quiesced); end
    checks++; if (sBus.awready !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_awready: got %b expected 1", sBus.awready); end
`ifdef AXI_MM_LIMITER_STATS_EN
    checks++; if (wrPeak !== 8'd0) begin errors++; $display("[TB] FAIL mid_peak_reset: got %0d expected 0", wrPeak); end
`endif
    tick();
    rst = 1'b0;
    tick();
    checks++; if (wrOut !== 8'd0 || errUf !== 1'b0) begin errors++; $display("[TB] FAIL mid_post: got wr=%0d err=%b expected 0 0", wrOut, errUf); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_read();
    test_simultaneous();
    test_drain();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
